servo_ctrl: RTL

Pen-lift servo controller that consumes a requested `Servo_p::ServoPosition_t` and drives the servo's 50 Hz PWM line. It uses the servo timing constants: 20 ms period, 1.0 ms pulse for UP, 1.5 ms pulse for DOWN. It sits between the command processor and the servo pin. A valid/ready request handshake accepts one move at a time, and a one-cycle `done` pulse reports it after the mechanical settle time has elapsed.

---
 rtl/servo_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/servo_ctrl.sv
// -----------------------------------------------------------------------------
// servo_ctrl
//   Pen-lift servo controller. Accepts one requested position at a time over a
//   trigger/rdy handshake, drives the servo's PWM line, and pulses done once the
//   servo has been held at the new duty for SETTLE_PERIODS full PWM periods.
//
//   Servo_p (declared here) holds the position type shared with the command
//   processor.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   trigger  in   move request, accepted only while rdy is high
//   pos      in   requested position, sampled on accept
//   rdy      out  high while idle and able to accept a request
//   done     out  one-cycle pulse when a move completes
//   cur_pos  out  position currently commanded on the PWM line
//   pwm_out  out  registered servo PWM
// -----------------------------------------------------------------------------
package Servo_p;
  typedef enum logic {
    SERVO_POS_UP   = 1'b0,
    SERVO_POS_DOWN = 1'b1
  } ServoPosition_t;
endpackage

module servo_ctrl
  import Servo_p::*;
#(
  parameter int CLK_EN_TICKS   = 5000,
  parameter int CLK_EN_BITS    = 13,
  parameter int PERIOD         = 200,
  parameter int DUTY_UP        = 10,
  parameter int DUTY_DOWN      = 15,
  parameter int SETTLE_PERIODS = 15
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           trigger,
  input  ServoPosition_t pos,
  output logic           rdy,
  output logic           done,
  output ServoPosition_t cur_pos,
  output logic           pwm_out
);

  localparam int PER_W = $clog2(PERIOD);
  localparam int SET_W = $clog2(SETTLE_PERIODS + 1);

  localparam logic [CLK_EN_BITS-1:0] PRESC_LAST  = CLK_EN_BITS'(CLK_EN_TICKS - 1);
  localparam logic [PER_W-1:0]       PER_LAST    = PER_W'(PERIOD - 1);
  localparam logic [SET_W-1:0]       SETTLE_LAST = SET_W'(SETTLE_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t                 state, state_nx;
  logic [CLK_EN_BITS-1:0] presc;
  logic [PER_W-1:0]       per_cnt;
  logic [PER_W-1:0]       duty;
  logic [SET_W-1:0]       settle_cnt;
  ServoPosition_t         tgt;

  logic tick;
  logic boundary;
  logic tgt_ld;
  logic load_new;
  logic settle_clr;
  logic settle_inc;

  function automatic logic [PER_W-1:0] duty_for(input ServoPosition_t p);
    duty_for = (p == SERVO_POS_DOWN) ? PER_W'(DUTY_DOWN) : PER_W'(DUTY_UP);
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign boundary = tick && (per_cnt == PER_LAST);

  // Prescaler: one tick every CLK_EN_TICKS clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CLK_EN_BITS'(1);
    end
  end

  // Period counter: position within the current PWM period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
    end else if (tick) begin
      per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
    end
  end

  // Duty / commanded position, only swapped on a period boundary so every
  // emitted pulse is whole
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty    <= PER_W'(DUTY_UP);
      cur_pos <= SERVO_POS_UP;
    end else if (load_new) begin
      duty    <= duty_for(tgt);
      cur_pos <= tgt;
    end
  end

  // PWM output register, one cycle behind per_cnt, free-running in every state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (per_cnt < duty);
    end
  end

  // Requested position, captured on accept
  always_ff @(posedge clk) begin
    if (tgt_ld) begin
      tgt <= pos;
    end
  end

  // Settle counter: boundaries seen at the new duty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (settle_clr) begin
      settle_cnt <= '0;
    end else if (settle_inc) begin
      settle_cnt <= settle_cnt + SET_W'(1);
    end
  end

  // Control FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tgt_ld     = 1'b0;
    load_new   = 1'b0;
    settle_clr = 1'b0;
    settle_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          tgt_ld   = 1'b1;
          state_nx = S_WAIT_EDGE;
        end
      end
      S_WAIT_EDGE: begin
        // The same-position check uses the latched tgt, so it is made one
        // cycle after accept; a no-op request completes without touching PWM.
        if (tgt == cur_pos) begin
          state_nx = S_DONE;
        end else if (boundary) begin
          load_new   = 1'b1;
          settle_clr = 1'b1;
          state_nx   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (boundary) begin
          settle_inc = 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign rdy  = (state == S_IDLE);
  assign done = (state == S_DONE);

endmodule
